// File: rtl/uart_tx_buf_if.sv
// Core-facing bus of the buffered UART transmitter.
// It carries the byte push strobe, the FIFO status flags and the serial line.
interface uart_tx_buf_if;
    // Push handshake: din is taken on every rising edge with din_valid high.
    // There is no ready. While full is high, a push is dropped and overflow latches.
    logic [7:0] din;
    logic       din_valid;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       busy;
    logic       txd;

    modport master (
        output din, din_valid,
        input  full, empty, overflow, busy, txd
    );

    modport slave (
        input  din, din_valid,
        output full, empty, overflow, busy, txd
    );
endinterface

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: bytes are queued in a power-of-two FIFO.
// A registered-output serializer drains them onto txd, LSB first.
module uart_tx_buf #(
    parameter int MEM         = 12,
    parameter int CLK_PER_BIT = 868
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_buf_if.slave bus,
    output logic [2:0]   dbg_state_o
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_e;

    localparam int          DEPTH     = 1 << MEM;
    localparam logic [15:0] BAUD_LAST = 16'(CLK_PER_BIT - 1);

    logic [7:0]     buffer_q [DEPTH];
    logic [MEM-1:0] top_q, top_d;
    logic [MEM-1:0] bottom_q;
    logic           overflow_q, overflow_d;
    logic [7:0]     rdata_q;
    logic [7:0]     shift_q;
    logic [2:0]     bitcnt_q;
    logic [15:0]    baud_q;
    logic           txd_q;
    state_e         state_q;

    logic full, empty, baud_end;

    // One slot is sacrificed so that full and empty are distinguishable from the pointers alone.
    assign empty    = (top_q == bottom_q);
    assign full     = ((top_q + MEM'(1)) == bottom_q);
    assign baud_end = (baud_q == BAUD_LAST);

    always_comb begin
        top_d      = top_q;
        overflow_d = overflow_q;
        if (bus.din_valid) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                top_d = top_q + MEM'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.din_valid && !full) begin
            buffer_q[top_q] <= bus.din;
        end
    end

    // The read port is registered: a byte written at one edge is in rdata_q after the next edge.
    // That is in time for FETCH to use it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q      <= '0;
            overflow_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            top_q      <= top_d;
            overflow_q <= overflow_d;
            rdata_q    <= buffer_q[bottom_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            bottom_q <= '0;
            shift_q  <= '0;
            bitcnt_q <= '0;
            baud_q   <= '0;
            txd_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    txd_q <= 1'b1;
                    if (!empty) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    state_q  <= START;
                    shift_q  <= rdata_q;
                    bottom_q <= bottom_q + MEM'(1);
                    bitcnt_q <= '0;
                    baud_q   <= '0;
                    txd_q    <= 1'b0;
                end
                START: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        state_q <= DATA;
                        txd_q   <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                DATA: begin
                    // txd is loaded one bit ahead, so the line changes exactly on the bit boundary.
                    if (baud_end) begin
                        baud_q   <= '0;
                        shift_q  <= {1'b0, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= STOP;
                            txd_q   <= 1'b1;
                        end else begin
                            txd_q <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.overflow = overflow_q;
    assign bus.busy     = (state_q != IDLE) | ~empty;
    assign bus.txd      = txd_q;
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: a line monitor decodes txd into a receive queue.
// Each scenario compares it against the bytes it pushed and the frame timing rules.
module tb_uart_tx_buf;
    localparam int CPB  = 4;
    localparam int MEMW = 2;
    localparam int FRAME = 10 * CPB;
    localparam int GAP   = 10 * CPB + 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] dbg_state;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    uart_tx_buf_if bus();

    uart_tx_buf #(.MEM(MEMW), .CLK_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_t[$];
    bit         rx_ok[$];

    // Line monitor: a frame starts at the first low sample and spans 10 cells of CPB samples.
    // A frame is clean if every cell is constant, the start cell is 0 and the stop cell is 1.
    bit         mon_active = 1'b0;
    int         mon_k;
    int         mon_start;
    bit         mon_clean;
    logic       mon_cell;
    logic [9:0] mon_frame;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && bus.txd === 1'b0) begin
                    mon_active = 1'b1;
                    mon_k      = 0;
                    mon_clean  = 1'b1;
                    mon_start  = cyc;
                    mon_frame  = '0;
                end
                if (mon_active) begin
                    if (mon_k % CPB == 0) mon_cell = bus.txd;
                    else if (bus.txd !== mon_cell) mon_clean = 1'b0;
                    if (mon_k % CPB == CPB - 1) mon_frame = {mon_cell, mon_frame[9:1]};
                    mon_k++;
                    if (mon_k == FRAME) begin
                        mon_active = 1'b0;
                        rx_q.push_back(mon_frame[8:1]);
                        rx_t.push_back(mon_start);
                        rx_ok.push_back(mon_clean && mon_frame[0] == 1'b0 && mon_frame[9] == 1'b1);
                    end
                end
            end
        end
    end

    task automatic clear_sb();
        exp_q.delete();
        rx_q.delete();
        rx_t.delete();
        rx_ok.delete();
    endtask

    // Called on a falling edge; the byte is sampled by the next rising edge.
    task automatic push_byte(input logic [7:0] b, input bit keep);
        bus.din       = b;
        bus.din_valid = 1'b1;
        if (keep) exp_q.push_back(b);
        @(negedge clk);
    endtask

    task automatic end_push();
        bus.din_valid = 1'b0;
        bus.din       = '0;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0 && !mon_active) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_txd_low(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (bus.txd === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        bit ok;
        n_vec++; if (bus.txd !== 1'b1) begin n_err++; $display("FAIL por_txd: got %b want 1", bus.txd); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL por_busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL por_empty: got %b want 1", bus.empty); end
        n_vec++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL por_full: got %b want 0", bus.full); end
        n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL por_overflow: got %b want 0", bus.overflow); end
        rst = 1'b0;
        @(negedge clk);
        push_byte(8'h00, 1'b0);
        push_byte(8'h00, 1'b0);
        end_push();
        wait_txd_low(10, ok);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (bus.txd !== 1'b1) begin n_err++; $display("FAIL async_txd: got %b want 1", bus.txd); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL async_busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL async_empty: got %b want 1", bus.empty); end
        n_vec++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL async_full: got %b want 0", bus.full); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_sb();
        @(negedge clk);
    endtask

    task automatic test_single();
        int e0;
        bit ok;
        push_byte(8'h55, 1'b1);
        e0 = cyc;
        end_push();
        n_vec++; if (bus.empty !== 1'b0) begin n_err++; $display("FAIL single_empty_e0: got %b want 0", bus.empty); end
        n_vec++; if (bus.txd !== 1'b1) begin n_err++; $display("FAIL single_txd_e0: got %b want 1", bus.txd); end
        @(negedge clk);
        n_vec++; if (bus.txd !== 1'b1) begin n_err++; $display("FAIL single_txd_e1: got %b want 1", bus.txd); end
        @(negedge clk);
        n_vec++; if (bus.txd !== 1'b0) begin n_err++; $display("FAIL single_txd_e2: got %b want 0", bus.txd); end
        while (cyc < e0 + 2 + FRAME - 1) @(negedge clk);
        n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL single_busy_stop: got %b want 1", bus.busy); end
        @(negedge clk);
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL single_busy_fall: got %b want 0", bus.busy); end
        wait_idle(20, ok);
        n_vec++; if (rx_q.size() != 1) begin n_err++; $display("FAIL single_count: got %0d want 1", rx_q.size()); end
        if (rx_q.size() == 1) begin
            n_vec++; if (rx_q[0] !== exp_q[0] || !rx_ok[0]) begin n_err++; $display("FAIL single_byte: got %h clean=%0d want %h clean=1", rx_q[0], rx_ok[0], exp_q[0]); end
            n_vec++; if (rx_t[0] != e0 + 2) begin n_err++; $display("FAIL single_start_cycle: got %0d want %0d", rx_t[0], e0 + 2); end
        end
        clear_sb();
    endtask

    task automatic test_back_to_back();
        int e0;
        bit ok;
        push_byte(8'hA5, 1'b1);
        e0 = cyc;
        push_byte(8'h00, 1'b1);
        push_byte(8'hFF, 1'b1);
        end_push();
        // The third byte is popped when its start bit begins, two frame gaps after the first.
        while (cyc < e0 + 2 + 2 * GAP - 1) @(negedge clk);
        n_vec++; if (bus.empty !== 1'b0) begin n_err++; $display("FAIL b2b_empty_fetch3: got %b want 0", bus.empty); end
        @(negedge clk);
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty_after3: got %b want 1", bus.empty); end
        wait_idle(200, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_idle: got timeout want idle"); end
        n_vec++; if (rx_q.size() != 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", rx_q.size()); end
        if (rx_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_vec++; if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin n_err++; $display("FAIL b2b_byte%0d: got %h clean=%0d want %h", i, rx_q[i], rx_ok[i], exp_q[i]); end
            end
            n_vec++; if (rx_t[0] != e0 + 2) begin n_err++; $display("FAIL b2b_first_start: got %0d want %0d", rx_t[0], e0 + 2); end
            for (int i = 1; i < 3; i++) begin
                n_vec++; if (rx_t[i] - rx_t[i-1] != GAP) begin n_err++; $display("FAIL b2b_spacing%0d: got %0d want %0d", i, rx_t[i] - rx_t[i-1], GAP); end
            end
        end
        clear_sb();
    endtask

    task automatic test_random();
        int n;
        bit ok;
        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) push_byte(8'($urandom), 1'b1);
            end_push();
            wait_idle(n * GAP + 30, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL rand%0d_idle: got timeout want idle", r); end
            n_vec++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand%0d_count: got %0d want %0d", r, rx_q.size(), exp_q.size()); end
            if (rx_q.size() == exp_q.size()) begin
                for (int i = 0; i < n; i++) begin
                    n_vec++; if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin n_err++; $display("FAIL rand%0d_byte%0d: got %h clean=%0d want %h", r, i, rx_q[i], rx_ok[i], exp_q[i]); end
                    if (i > 0) begin
                        n_vec++; if (rx_t[i] - rx_t[i-1] != GAP) begin n_err++; $display("FAIL rand%0d_spacing%0d: got %0d want %0d", r, i, rx_t[i] - rx_t[i-1], GAP); end
                    end
                end
            end
            clear_sb();
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        for (int i = 1; i <= 10; i++) begin
            push_byte(8'(i), 1'b1);
            end_push();
            wait_idle(GAP + 20, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_idle%0d: got timeout want idle", i); end
        end
        n_vec++; if (rx_q.size() != 10) begin n_err++; $display("FAIL wrap_count: got %0d want 10", rx_q.size()); end
        if (rx_q.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                n_vec++; if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin n_err++; $display("FAIL wrap_byte%0d: got %h clean=%0d want %h", i, rx_q[i], rx_ok[i], exp_q[i]); end
            end
        end
        clear_sb();
    endtask

    task automatic test_full_overflow();
        bit ok;
        push_byte(8'h11, 1'b1);
        end_push();
        wait_txd_low(10, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL full_start: got timeout want start bit"); end
        push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1);
        push_byte(8'h44, 1'b1);
        end_push();
        n_vec++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL full_set: got %b want 1", bus.full); end
        n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL full_no_ovf_yet: got %b want 0", bus.overflow); end
        push_byte(8'h55, 1'b0);
        end_push();
        n_vec++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", bus.overflow); end
        n_vec++; if (bus.full !== 1'b1) begin n_err++; $display("FAIL full_hold: got %b want 1", bus.full); end
        wait_idle(5 * GAP, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL full_idle: got timeout want idle"); end
        n_vec++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
        n_vec++; if (rx_q.size() != 4) begin n_err++; $display("FAIL full_count: got %0d want 4", rx_q.size()); end
        if (rx_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_vec++; if (rx_q[i] !== exp_q[i] || !rx_ok[i]) begin n_err++; $display("FAIL full_byte%0d: got %h clean=%0d want %h", i, rx_q[i], rx_ok[i], exp_q[i]); end
            end
        end
        clear_sb();
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b0;
        bit ok;
        b0 = 8'($urandom);
        push_byte(b0, 1'b0);
        push_byte(8'($urandom), 1'b0);
        push_byte(8'($urandom), 1'b0);
        end_push();
        wait_txd_low(10, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL mid_start: got timeout want start bit"); end
        repeat (4 * CPB + 1) @(negedge clk);
        n_vec++; if (bus.txd !== b0[3]) begin n_err++; $display("FAIL mid_bit3: got %b want %b", bus.txd, b0[3]); end
        #2 rst = 1'b1;
        #1;
        n_vec++; if (bus.txd !== 1'b1) begin n_err++; $display("FAIL mid_txd: got %b want 1", bus.txd); end
        n_vec++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL mid_empty: got %b want 1", bus.empty); end
        n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
        n_vec++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL mid_overflow: got %b want 0", bus.overflow); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_sb();
        @(negedge clk);
        push_byte(8'hC3, 1'b1);
        end_push();
        wait_idle(GAP + 20, ok);
        repeat (3 * GAP) @(negedge clk);
        n_vec++; if (rx_q.size() != 1) begin n_err++; $display("FAIL mid_count: got %0d want 1", rx_q.size()); end
        if (rx_q.size() == 1) begin
            n_vec++; if (rx_q[0] !== 8'hC3 || !rx_ok[0]) begin n_err++; $display("FAIL mid_byte: got %h clean=%0d want c3", rx_q[0], rx_ok[0]); end
        end
        clear_sb();
    endtask

    initial begin
        bus.din       = '0;
        bus.din_valid = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_wrap();
        test_full_overflow();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: got no completion by %0t want completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end
endmodule
